// File: rtl/vmx_mm_responder_if.sv
// Host bus for vmx_mm_responder: a request/acknowledge port carrying
// 32-bit accesses. The host holds h_req until it sees the h_ack pulse.
interface vmx_mm_responder_if;
  logic        h_req;
  logic        h_we;
  logic [9:0]  h_addr;
  logic [31:0] h_wdata;
  logic        h_ack;
  logic [31:0] h_rdata;

  modport master (
    output h_req, h_we, h_addr, h_wdata,
    input  h_ack, h_rdata
  );

  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    output h_ack, h_rdata
  );
endinterface

// File: rtl/vmx_mm_responder.sv
// vmx_mm_responder: shared 64-bit buffer between a vector engine and a
// 32-bit host, plus a small control/status register block.
// The engine side has a 1-cycle registered read port and a double-word
// write port. The host side accesses either buffer halves, or registers
// when h_addr[9] is set.
// Optional feature: define VMX_MM_DONE_IRQ_EN to add the irq output
// (STATUS.done gated by CTRL bit2). Without it, CTRL bit2 reads 0.
module vmx_mm_responder #(
  parameter int MEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  vmx_mm_responder_if.slave  hbus,
  input  logic [7:0]         eng_addr,
  input  logic               eng_wr_en,
  input  logic [127:0]       eng_wdata,
  output logic [63:0]        eng_rdata,
  output logic [31:0]        eng_ctrl,
  input  logic [31:0]        eng_flag,
  output logic [7:0]         eng_rbase,
  output logic [7:0]         eng_wbase
`ifdef VMX_MM_DONE_IRQ_EN
  ,
  output logic               irq
`endif
);

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_MEM  = 2'd2,
    H_ACK  = 2'd3
  } h_state_t;

  // Buffer storage; deliberately not reset so data survives rst.
  logic [63:0] mem_r [MEM_DEPTH];

  h_state_t    h_state_r;
  logic [8:0]  lat_addr_r;
  logic        lat_we_r;
  logic [31:0] lat_wdata_r;
  logic        h_ack_r;
  logic [31:0] h_rdata_r;
  logic [63:0] eng_rdata_r;

  logic        ctrl0_r;
  logic        start_r;
  logic [7:0]  rbase_r;
  logic [7:0]  wbase_r;
  logic        done_r;
  logic        err_r;
  logic [2:0]  flag_prev_r;
  logic [15:0] jobcnt_r;
  logic        ien_s;

  logic        eng_idle_s;
  logic        job_end_s;
  logic        done_set_s;
  logic        reg_acc_s;
  logic        reg_wr_s;
  logic        status_rd_s;
  logic        ctrl_wr_s;
  logic        start_ok_s;
  logic        start_rej_s;
  logic        mem_wr_s;
  logic [7:0]  eng_addr_nxt_s;
  logic [31:0] reg_rdata_s;
  logic [31:0] ctrl_rd_s;
  logic [63:0] mem_word_s;
  logic [31:0] mem_half_s;
  logic        unused_flag_s;

  assign unused_flag_s  = ^eng_flag[31:3];
  assign eng_idle_s     = (eng_flag[2:0] == 3'd0);
  assign job_end_s      = (flag_prev_r == 3'd4) && eng_idle_s;
  // An engine that drops to idle because soft reset was forced has not
  // completed a job, so done is suppressed while CTRL bit0 is held.
  assign done_set_s     = job_end_s && !ctrl0_r;
  assign eng_addr_nxt_s = eng_addr + 8'd1;

  assign reg_acc_s   = (h_state_r == H_IDLE) && hbus.h_req && hbus.h_addr[9];
  assign reg_wr_s    = reg_acc_s && hbus.h_we;
  assign status_rd_s = reg_acc_s && !hbus.h_we && (hbus.h_addr[8:0] == 9'h001);
  assign ctrl_wr_s   = reg_wr_s && (hbus.h_addr[8:0] == 9'h000);
  // The start is judged against the soft-reset value being written, so a
  // single write of 0x3 cannot kick an engine that is being held in reset.
  assign start_ok_s  = ctrl_wr_s && hbus.h_wdata[1] && eng_idle_s && !hbus.h_wdata[0];
  assign start_rej_s = ctrl_wr_s && hbus.h_wdata[1] && !start_ok_s;
  assign mem_wr_s    = (h_state_r == H_MEM) && lat_we_r;

  assign ctrl_rd_s   = {29'd0, ien_s, 1'b0, ctrl0_r};

  // Register read multiplexer; unmapped addresses return zero.
  always_comb begin
    reg_rdata_s = 32'd0;
    case (hbus.h_addr[8:0])
      9'h000:  reg_rdata_s = ctrl_rd_s;
      9'h001:  reg_rdata_s = {27'd0, eng_flag[2:0], err_r, done_r};
      9'h002:  reg_rdata_s = {24'd0, rbase_r};
      9'h003:  reg_rdata_s = {24'd0, wbase_r};
      9'h004:  reg_rdata_s = {16'd0, jobcnt_r};
      default: reg_rdata_s = 32'd0;
    endcase
  end

  // Host view of the buffer: select the 32-bit half of the latched word.
  always_comb begin
    mem_word_s = mem_r[lat_addr_r[8:1]];
    if (lat_addr_r[0]) begin
      mem_half_s = mem_word_s[63:32];
    end else begin
      mem_half_s = mem_word_s[31:0];
    end
  end

  // Buffer writes: host half-word first, engine double-word wins on overlap.
  always_ff @(posedge clk) begin
    if (mem_wr_s) begin
      if (lat_addr_r[0]) begin
        mem_r[lat_addr_r[8:1]][63:32] <= lat_wdata_r;
      end else begin
        mem_r[lat_addr_r[8:1]][31:0] <= lat_wdata_r;
      end
    end
    if (eng_wr_en) begin
      mem_r[eng_addr]       <= eng_wdata[63:0];
      mem_r[eng_addr_nxt_s] <= eng_wdata[127:64];
    end
  end

  // Engine read port: one-cycle registered read every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_rdata_r <= 64'd0;
    end else begin
      eng_rdata_r <= mem_r[eng_addr];
    end
  end

  // Host FSM: sequences register and buffer accesses and produces h_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state_r   <= H_IDLE;
      lat_addr_r  <= 9'd0;
      lat_we_r    <= 1'b0;
      lat_wdata_r <= 32'd0;
      h_ack_r     <= 1'b0;
      h_rdata_r   <= 32'd0;
    end else begin
      h_ack_r <= 1'b0;
      case (h_state_r)
        H_IDLE: begin
          if (hbus.h_req) begin
            lat_addr_r  <= hbus.h_addr[8:0];
            lat_we_r    <= hbus.h_we;
            lat_wdata_r <= hbus.h_wdata;
            if (hbus.h_addr[9]) begin
              if (!hbus.h_we) begin
                h_rdata_r <= reg_rdata_s;
              end
              h_ack_r   <= 1'b1;
              h_state_r <= H_ACK;
            end else if (eng_idle_s) begin
              h_state_r <= H_MEM;
            end else begin
              h_state_r <= H_WAIT;
            end
          end
        end
        H_WAIT: begin
          if (eng_idle_s) begin
            h_state_r <= H_MEM;
          end
        end
        H_MEM: begin
          if (!lat_we_r) begin
            h_rdata_r <= mem_half_s;
          end
          h_ack_r   <= 1'b1;
          h_state_r <= H_ACK;
        end
        H_ACK: begin
          h_state_r <= H_IDLE;
        end
        default: begin
          h_state_r <= H_IDLE;
        end
      endcase
    end
  end

  // Control registers: soft-reset level, start pulse and base addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl0_r <= 1'b0;
      start_r <= 1'b0;
      rbase_r <= 8'd0;
      wbase_r <= 8'd0;
    end else begin
      start_r <= start_ok_s;
      if (ctrl_wr_s) begin
        ctrl0_r <= hbus.h_wdata[0];
      end
      if (reg_wr_s && (hbus.h_addr[8:0] == 9'h002)) begin
        rbase_r <= hbus.h_wdata[7:0];
      end
      if (reg_wr_s && (hbus.h_addr[8:0] == 9'h003)) begin
        wbase_r <= hbus.h_wdata[7:0];
      end
    end
  end

  // Status tracking: done/err flags with read-clear, job counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      flag_prev_r <= 3'd0;
      jobcnt_r    <= 16'd0;
    end else begin
      flag_prev_r <= eng_flag[2:0];
      if (done_set_s) begin
        done_r <= 1'b1;
      end else if (status_rd_s) begin
        done_r <= 1'b0;
      end
      if (start_rej_s) begin
        err_r <= 1'b1;
      end else if (status_rd_s) begin
        err_r <= 1'b0;
      end
      if (job_end_s && (jobcnt_r != 16'hFFFF)) begin
        jobcnt_r <= jobcnt_r + 16'd1;
      end
    end
  end

`ifdef VMX_MM_DONE_IRQ_EN
  logic ien_r;

  // Interrupt enable bit held in CTRL bit2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ien_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      ien_r <= hbus.h_wdata[2];
    end
  end

  assign ien_s = ien_r;
  assign irq   = done_r & ien_r;
`else
  assign ien_s = 1'b0;
`endif

  assign eng_rdata    = eng_rdata_r;
  assign eng_ctrl     = {30'd0, start_r, ctrl0_r};
  assign eng_rbase    = rbase_r;
  assign eng_wbase    = wbase_r;
  assign hbus.h_ack   = h_ack_r;
  assign hbus.h_rdata = h_rdata_r;

endmodule

// File: tb/tb_vmx_mm_responder.sv
// Randomised self-checking bench for vmx_mm_responder. A transaction-level
// model (buffer array plus register variables) predicts every result.
module tb_vmx_mm_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   eng_addr;
  logic         eng_wr_en;
  logic [127:0] eng_wdata;
  logic [63:0]  eng_rdata;
  logic [31:0]  eng_ctrl;
  logic [31:0]  eng_flag;
  logic [7:0]   eng_rbase;
  logic [7:0]   eng_wbase;
`ifdef VMX_MM_DONE_IRQ_EN
  logic         irq;
`endif

  vmx_mm_responder_if hbus ();

  always #5 clk = ~clk;

  vmx_mm_responder #(.MEM_DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .hbus      (hbus),
    .eng_addr  (eng_addr),
    .eng_wr_en (eng_wr_en),
    .eng_wdata (eng_wdata),
    .eng_rdata (eng_rdata),
    .eng_ctrl  (eng_ctrl),
    .eng_flag  (eng_flag),
    .eng_rbase (eng_rbase),
    .eng_wbase (eng_wbase)
`ifdef VMX_MM_DONE_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  int checks = 0;
  int errors = 0;
  int pulse_seen;

  // reference model
  logic [63:0] m_mem [256];
  logic [7:0]  m_rbase, m_wbase;
  logic        m_ctrl0, m_done, m_err;
  int          m_jobcnt;
  logic [2:0]  m_flag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_reg(input int idx);
    case (idx)
      0: return {31'd0, m_ctrl0};
      1: return {27'd0, m_flag, m_err, m_done};
      2: return {24'd0, m_rbase};
      3: return {24'd0, m_wbase};
      4: return m_jobcnt[31:0] & 32'h0000_FFFF;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_rbase = 8'd0; m_wbase = 8'd0; m_ctrl0 = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_jobcnt = 0;
  endtask

  // change engine state; a 4 -> 0 step is a job completion
  task automatic set_flag(input logic [2:0] v);
    @(posedge clk); #1;
    if (m_flag == 3'd4 && v == 3'd0) begin
      if (!m_ctrl0) m_done = 1'b1;
      if (m_jobcnt < 65535) m_jobcnt++;
    end
    m_flag = v;
    eng_flag = {29'd0, v};
  endtask

  // one host transaction; lat = cycles from request to ack, -1 on timeout
  task automatic host_xfer(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                           input logic [2:0] flag_at_req,
                           output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    hbus.h_req = 1'b1; hbus.h_we = we; hbus.h_addr = addr; hbus.h_wdata = wd;
    eng_flag = {29'd0, flag_at_req};
    lat = -1; rd = 32'd0; pulse_seen = 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (eng_ctrl[1]) pulse_seen++;
      if (hbus.h_ack) begin lat = n; rd = hbus.h_rdata; end
    end
    @(posedge clk); #1;
    hbus.h_req = 1'b0; hbus.h_we = 1'b0;
    @(negedge clk);
    if (eng_ctrl[1]) pulse_seen++;
    chk("ack_single_cycle", {63'd0, hbus.h_ack}, 64'd0);
  endtask

  task automatic host_write_mem(input logic [7:0] w, input logic h, input logic [31:0] d);
    logic [31:0] rd; int lat;
    host_xfer(1'b1, {1'b0, w, h}, d, m_flag, rd, lat);
    chk("mem_wr_latency", lat, 2);
    if (h) m_mem[w][63:32] = d; else m_mem[w][31:0] = d;
  endtask

  task automatic host_read_mem(input logic [7:0] w, input logic h, input string tag);
    logic [31:0] rd, exp; int lat;
    exp = h ? m_mem[w][63:32] : m_mem[w][31:0];
    host_xfer(1'b0, {1'b0, w, h}, 32'd0, m_flag, rd, lat);
    chk("mem_rd_latency", lat, 2);
    chk(tag, rd, exp);
  endtask

  task automatic reg_write(input int idx, input logic [31:0] d);
    logic [31:0] rd; int lat; int exp_pulse;
    exp_pulse = 0;
    host_xfer(1'b1, 10'h200 | idx[9:0], d, m_flag, rd, lat);
    chk("reg_wr_latency", lat, 1);
    case (idx)
      0: begin
        if (d[1]) begin
          if (m_flag == 3'd0 && !d[0]) exp_pulse = 1; else m_err = 1'b1;
        end
        m_ctrl0 = d[0];
        chk("start_pulse_cycles", pulse_seen, exp_pulse);
      end
      2: m_rbase = d[7:0];
      3: m_wbase = d[7:0];
      default: ;
    endcase
  endtask

  task automatic reg_read_chk(input int idx, input string tag);
    logic [31:0] rd, exp; int lat;
    exp = model_reg(idx);
    host_xfer(1'b0, 10'h200 | idx[9:0], 32'd0, m_flag, rd, lat);
    chk("reg_rd_latency", lat, 1);
    chk(tag, rd, exp);
    if (idx == 1) begin m_done = 1'b0; m_err = 1'b0; end
  endtask

  task automatic eng_write(input logic [7:0] a, input logic [127:0] d);
    logic [7:0] a1;
    @(posedge clk); #1;
    eng_addr = a; eng_wdata = d; eng_wr_en = 1'b1;
    @(posedge clk); #1;
    eng_wr_en = 1'b0;
    a1 = a + 8'd1;
    m_mem[a] = d[63:0];
    m_mem[a1] = d[127:64];
  endtask

  task automatic eng_read_chk(input logic [7:0] a, input string tag);
    @(posedge clk); #1;
    eng_addr = a;
    @(posedge clk); @(negedge clk);
    chk(tag, eng_rdata, m_mem[a]);
  endtask

  // wait for a held request to be acknowledged; returns cycles or -1
  task automatic wait_ack(input int budget, output int lat, output logic [31:0] rd);
    lat = -1; rd = 32'd0;
    for (int n = 1; n <= budget && lat < 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (hbus.h_ack) begin lat = n; rd = hbus.h_rdata; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp;
    int lat, op;
    logic [7:0] w;
    logic h;

    rst = 1'b1;
    hbus.h_req = 1'b0; hbus.h_we = 1'b0; hbus.h_addr = 10'd0; hbus.h_wdata = 32'd0;
    eng_addr = 8'd0; eng_wr_en = 1'b0; eng_wdata = 128'd0; eng_flag = 32'd0;
    m_flag = 3'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_eng_ctrl", eng_ctrl, 64'd0);
    chk("rst_rbase", eng_rbase, 64'd0);
    chk("rst_wbase", eng_wbase, 64'd0);
    chk("rst_h_ack", hbus.h_ack, 64'd0);
    chk("rst_h_rdata", hbus.h_rdata, 64'd0);
    chk("rst_eng_rdata", eng_rdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // fill the whole buffer from the engine side
    for (int i = 0; i < 128; i++) begin
      eng_write(8'(2 * i), {$urandom(), $urandom(), $urandom(), $urandom()});
    end

    // basic host write then engine read
    host_write_mem(8'd0, 1'b0, 32'h1111_1111);
    host_write_mem(8'd0, 1'b1, 32'h2222_2222);
    eng_read_chk(8'd0, "eng_rd_after_host_wr");
    chk("eng_rd_literal", eng_rdata, 64'h2222_2222_1111_1111);

    // engine double write wrapping 255 -> 0
    eng_write(8'd255, {64'hB, 64'hA});
    host_read_mem(8'd255, 1'b0, "wrap_lo_word");
    host_read_mem(8'd0, 1'b0, "wrap_hi_word");

    // randomised mix of traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 6);
      w = 8'($urandom_range(0, 255));
      h = 1'($urandom_range(0, 1));
      case (op)
        0: eng_write(w, {$urandom(), $urandom(), $urandom(), $urandom()});
        1: host_write_mem(w, h, $urandom());
        2: host_read_mem(w, h, "rand_host_rd");
        3: eng_read_chk(w, "rand_eng_rd");
        4: reg_write($urandom_range(2, 3), $urandom());
        5: reg_read_chk($urandom_range(0, 4), "rand_reg_rd");
        default: begin
          op = $urandom_range(5, 511);
          reg_write(op, $urandom());
          reg_read_chk(op, "unmapped_reg_rd");
        end
      endcase
    end
    chk("rbase_out", eng_rbase, m_rbase);
    chk("wbase_out", eng_wbase, m_wbase);

    // start pulse accepted / rejected
    reg_write(0, 32'h2);
    chk("eng_ctrl_upper_zero", eng_ctrl[31:2], 64'd0);
    set_flag(3'd3);
    reg_write(0, 32'h2);
    reg_read_chk(1, "status_err_busy");
    chk("status_err_literal", 64'(m_flag) << 2, 64'hC);
    set_flag(3'd0);
    reg_write(0, 32'h3);
    chk("soft_reset_level", eng_ctrl[0], 64'd1);
    reg_read_chk(1, "status_err_softrst");
    reg_write(0, 32'h0);

    // job completion
    set_flag(3'd4);
    set_flag(3'd0);
    reg_read_chk(1, "status_done");
    reg_read_chk(4, "jobcnt_one");
    reg_read_chk(1, "status_cleared");

    // completion coincident with a STATUS read keeps done
    set_flag(3'd4);
    @(posedge clk);
    exp = {27'd0, 3'd0, m_err, m_done};
    host_xfer(1'b0, 10'h201, 32'd0, 3'd0, rd, lat);
    chk("coincident_rd_lat", lat, 1);
    chk("coincident_rd_val", rd, exp);
    m_err = 1'b0; m_done = 1'b1; m_flag = 3'd0; m_jobcnt++;
    reg_read_chk(1, "done_survives_clear");
    reg_read_chk(4, "jobcnt_two");

    // soft reset mid-job does not set done
    set_flag(3'd4);
    reg_write(0, 32'h1);
    set_flag(3'd0);
    reg_read_chk(1, "no_done_on_softrst");
    reg_write(0, 32'h0);

    // host memory read held off while engine busy
    set_flag(3'd2);
    @(posedge clk); #1;
    hbus.h_req = 1'b1; hbus.h_we = 1'b0; hbus.h_addr = {1'b0, 8'd7, 1'b1};
    wait_ack(5, lat, rd);
    chk("busy_no_ack", lat, -1);
    @(posedge clk); #1;
    eng_flag = 32'd0; m_flag = 3'd0;
    wait_ack(20, lat, rd);
    chk("busy_release_latency", lat, 2);
    chk("busy_release_data", rd, m_mem[7][63:32]);
    @(posedge clk); #1;
    hbus.h_req = 1'b0;

    // reset while waiting on a busy engine
    reg_write(2, 32'h5A);
    reg_write(3, 32'hA5);
    reg_write(0, 32'h1);
    set_flag(3'd2);
    @(posedge clk); #1;
    hbus.h_req = 1'b1; hbus.h_we = 1'b0; hbus.h_addr = {1'b0, 8'd9, 1'b0};
    wait_ack(3, lat, rd);
    chk("wait_no_ack", lat, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_eng_ctrl", eng_ctrl, 64'd0);
    chk("midrst_rbase", eng_rbase, 64'd0);
    chk("midrst_wbase", eng_wbase, 64'd0);
    chk("midrst_h_ack", hbus.h_ack, 64'd0);
    hbus.h_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wait_ack(3, lat, rd);
    chk("post_rst_no_ack", lat, -1);
    set_flag(3'd0);
    for (int i = 0; i <= 4; i++) reg_read_chk(i, "post_rst_reg");
    host_read_mem(8'd9, 1'b0, "post_rst_mem_lo");
    host_read_mem(8'd9, 1'b1, "post_rst_mem_hi");
    eng_read_chk(8'd9, "post_rst_eng_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
